// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial subtractor controller driving one full-subtract cell
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dif,
    output logic             bor
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] wr;
    logic [CW-1:0]    cnt;
    logic             br;

    logic x, y, bin;
    logic d1, b1, d, b2, bout;
    logic accept;
    logic last_bit;

    // One full-subtract stage built from two half-subtract cells
    always_comb begin
        x    = sa[0];
        y    = sb[0];
        bin  = br;
        d1   = x ^ y;
        b1   = ~x & y;
        d    = d1 ^ bin;
        b2   = ~d1 & bin;
        bout = b1 | b2;
    end

    assign accept   = (state == IDLE) && start;
    assign last_bit = (state == RUN) && (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs registered from the next state so they never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == DONE);
        end
    end

    // Operand shifters, work register, borrow chain and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa  <= '0;
            sb  <= '0;
            wr  <= '0;
            br  <= 1'b0;
            cnt <= '0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            wr  <= '0;
            br  <= 1'b0;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= {1'b0, sa[WIDTH-1:1]};
            sb  <= {1'b0, sb[WIDTH-1:1]};
            wr  <= {d, wr[WIDTH-1:1]};
            br  <= bout;
            cnt <= cnt + 1'b1;
        end
    end

    // Result registers only move on the last processed bit, holding otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dif <= '0;
            bor <= 1'b0;
        end else if (last_bit) begin
            dif <= {d, wr[WIDTH-1:1]};
            bor <= bout;
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - self-checking bench for serial_sub_ctrl
`timescale 1ns/1ps
module tb_serial_sub_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] dif;
    logic       bor;

    int nchecks = 0;
    int nerrs   = 0;

    logic [7:0] prev_dif;
    logic       prev_bor;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .dif   (dif),
        .bor   (bor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned difference modulo 256 and borrow when a < b
    function automatic logic [7:0] ref_dif(input logic [7:0] x, input logic [7:0] y);
        int t;
        t = int'(x) - int'(y);
        if (t < 0) t = t + 256;
        return t[7:0];
    endfunction

    function automatic logic ref_bor(input logic [7:0] x, input logic [7:0] y);
        return (int'(x) < int'(y));
    endfunction

    // One full request: checks latency, hold of previous result, done width, result
    task automatic do_op(input string tag, input logic [7:0] x, input logic [7:0] y);
        int lat;
        bit seen;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = $urandom; b = $urandom;
        lat = 0; seen = 0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) seen = 1;
            else if (dif !== prev_dif) check({tag, "_hold"}, dif, prev_dif);
        end
        check({tag, "_lat"}, lat, 8);
        check({tag, "_dif"}, dif, ref_dif(x, y));
        check({tag, "_bor"}, bor, ref_bor(x, y));
        @(negedge clk);
        check({tag, "_done_clr"}, {busy, done}, 2'b00);
        prev_dif = ref_dif(x, y);
        prev_bor = ref_bor(x, y);
    endtask

    initial begin
        int ndone;
        int last_done;
        int low_run;
        bit seen_busy;
        logic [7:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
        prev_dif = 8'h00; prev_bor = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_low", {busy, done, dif, bor}, 11'h000);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_idle", {busy, done, dif, bor}, 11'h000);

        // Basic and borrow-ripple vectors
        do_op("v05_03", 8'h05, 8'h03);
        do_op("v03_05", 8'h03, 8'h05);
        do_op("v00_01", 8'h00, 8'h01);
        do_op("vFF_FF", 8'hFF, 8'hFF);
        do_op("v80_7F", 8'h80, 8'h7F);

        // Busy rejection: second start and operand changes during RUN ignored
        @(negedge clk);
        a = 8'h10; b = 8'h01; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) begin start = 1'b1; a = 8'hAA; b = 8'h55; end
            if (i == 3) begin start = 1'b0; a = 8'h33; b = 8'h77; end
            @(negedge clk);
            if (done) begin
                ndone++;
                check("rej_dif", dif, 8'h0F);
                check("rej_bor", bor, 1'b0);
            end else if (ndone == 0) begin
                check("rej_hold", dif, prev_dif);
            end
        end
        check("rej_ndone", ndone, 1);
        prev_dif = 8'h0F; prev_bor = 1'b0;

        // Back-to-back with start held high
        @(negedge clk);
        a = 8'h20; b = 8'h01; start = 1'b1;
        ndone = 0; last_done = -1; low_run = 0; seen_busy = 0;
        for (int c = 0; c < 42; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check("b2b_dif", dif, 8'h1F);
                if (last_done >= 0) check("b2b_period", c - last_done, 10);
                last_done = c;
            end
            if (busy) begin
                if (seen_busy && low_run != 0) check("b2b_gap", low_run, 1);
                seen_busy = 1;
                low_run = 0;
            end else if (seen_busy) begin
                low_run++;
            end
        end
        check("b2b_ndone", ndone, 4);
        start = 1'b0;
        repeat (12) @(negedge clk);
        prev_dif = 8'h1F; prev_bor = 1'b0;
        check("b2b_idle", {busy, done}, 2'b00);

        // Reset mid-run
        @(negedge clk);
        a = 8'hC3; b = 8'h11; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_imm", {busy, done, dif, bor}, 11'h000);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mrst_nodone", ndone, 0);
        check("mrst_hold", {busy, dif, bor}, 10'h000);
        prev_dif = 8'h00; prev_bor = 1'b0;
        do_op("v09_04", 8'h09, 8'h04);

        // Randomized operands against the reference
        for (int n = 0; n < 24; n++) begin
            ra = $urandom; rb = $urandom;
            do_op("rand", ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtractor controller. It computes `dif = a - b` over WIDTH clock cycles by sequencing one single-bit full-subtract stage, built from two half-subtract cells, through the operand bits LSB first. A registered borrow chains each bit into the next. It sits between a requester using a start/done handshake and the shared 1-bit subtract datapath, so a single subtract cell can serve wide operands.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal values are ≥ 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: request; sampled only in IDLE.
- `a`  in  WIDTH: minuend; sampled on the accepting edge only.
- `b`  in  WIDTH: subtrahend; sampled on the accepting edge only.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: one-cycle completion pulse.
- `dif`  out  WIDTH: result register, `(a - b) mod 2^WIDTH`.
- `bor`  out  1: final borrow out; 1 iff `a < b` (unsigned).

## Operation
- **States**
  - IDLE: waiting for a request.
  - RUN: bit processing.
  - DONE: completion, lasts exactly one cycle.
- **State transitions**
  - IDLE → RUN when `start` = 1.
  - RUN → DONE when the bit counter reaches WIDTH-1.
  - DONE → IDLE unconditionally.
- **Accept (IDLE with `start` = 1)**
  - Load `a` into shift register `sa` and `b` into shift register `sb`.
  - Clear the borrow register `br` to 0.
  - Clear the counter `cnt` to 0. `cnt` is `$clog2(WIDTH)` bits wide.
  - Clear the work register `wr`.
- **Each RUN cycle, bit stage on `x = sa[0]`, `y = sb[0]`, `bin = br`**
  - First half-subtract: `d1 = x ^ y`, `b1 = ~x & y`.
  - Second half-subtract: `d = d1 ^ bin`, `b2 = ~d1 & bin`.
  - Borrow out: `bout = b1 | b2`.
  - Update registers:
    - `sa` and `sb` shift right by 1.
    - `wr` shifts right with `d` entering at the MSB.
    - `br <= bout`.
    - `cnt` increments.
- **On the RUN → DONE edge**
  - `dif <=` the final `wr` value, including the bit computed in that cycle.
  - `bor <=` the final `bout`.
- **Output holding:** `dif` and `bor` change only on the RUN → DONE edge. They hold the previous result at all other times, including throughout RUN.
- **`start` outside IDLE:** ignored while in RUN or DONE. Operand changes during RUN have no effect.
- **`busy`** is the decode `state != IDLE`. **`done`** is the decode `state == DONE`. Both outputs are glitch-free from registered state.
- **Reset mid-operation:** `rst_n` low forces the following immediately (asynchronously); the in-flight operation is discarded with no `done`.
  - State IDLE.
  - `busy` = 0, `done` = 0, `dif` = 0, `bor` = 0.
  - All internal registers 0.
- **Reset values:** `busy` 0, `done` 0, `dif` 0, `bor` 0.

## Timing
- **Cycle-level sequence**, with `start` sampled high at edge k while in IDLE:
  - Edge k: operands latched; `busy` = 1 after this edge.
  - Edges k+1 … k+WIDTH: bits 0 … WIDTH-1 processed.
  - Edge k+WIDTH: `dif`/`bor` updated; `done` = 1 for the following cycle.
  - Edge k+WIDTH+1: return to IDLE; `busy` = 0, `done` = 0.
- **Latency:** the result is visible WIDTH cycles after the accepting edge.
- **Throughput:** one operation per WIDTH+2 cycles when `start` is held high continuously. The next accept happens on edge k+WIDTH+2.
- **`start` during the DONE cycle** is not accepted. It must still be high in IDLE to be taken.
- **Reset release:** the first `start` can be accepted on the first rising edge after `rst_n` deasserts.

## Test plan
All cases use WIDTH = 8.
- **Reset check:** `rst_n` low, then high with `start` = 0 → `busy` = 0, `done` = 0, `dif` = 0x00, `bor` = 0, held indefinitely.
- **Basic vectors:** `done` after exactly 8 cycles in each case.
  - `a` = 0x05, `b` = 0x03, start pulse → `dif` = 0x02, `bor` = 0.
  - `a` = 0x03, `b` = 0x05 → `dif` = 0xFE, `bor` = 1.
- **Borrow-ripple edges:**
  - `a` = 0x00, `b` = 0x01 → `dif` = 0xFF, `bor` = 1.
  - `a` = 0xFF, `b` = 0xFF → `dif` = 0x00, `bor` = 0.
  - `a` = 0x80, `b` = 0x7F → `dif` = 0x01, `bor` = 0.
- **Busy rejection:** start 0x10 − 0x01, then pulse `start` with `a` = 0xAA, `b` = 0x55 two cycles later and change the operands mid-run.
  - Exactly one `done`; `dif` = 0x0F, `bor` = 0.
  - `dif` holds the prior result until the DONE edge.
- **Back-to-back:** `start` held high with `a` = 0x20, `b` = 0x01 → `done` pulses every 10 cycles, `dif` = 0x1F each time, `busy` low for exactly one cycle between operations.
- **Reset mid-run:** assert `rst_n` low 4 cycles into an operation → `busy`/`done`/`dif`/`bor` go to 0 immediately with no `done` pulse. The next request after release, 0x09 − 0x04, completes normally with `dif` = 0x05.
